// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: opcode constants, fetch-queue entry type and immediate decoders
package fetch_unit_pkg;
    localparam logic [6:0] OJAL = 7'b1101111;
    localparam logic [6:0] OJALR = 7'b1100111;
    localparam logic [6:0] OB = 7'b1100011;
    localparam logic [31:0] HALT_INS = 32'h0ff00513;
    localparam logic [1:0] OC_Q1 = 2'b01;
    localparam logic [1:0] OC_Q2 = 2'b10;
    localparam logic [2:0] CF3_J = 3'b101;
    localparam logic [2:0] CF3_JAL = 3'b001;
    localparam logic [2:0] CF3_JR = 3'b100;
    localparam logic [2:0] CF3_BEQZ = 3'b110;
    localparam logic [2:0] CF3_BNEZ = 3'b111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        pred;
        logic [31:0] alt;
    } fq_entry_t;

    function automatic logic [31:0] j_imm(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] cj_imm(input logic [31:0] i);
        return {{21{i[12]}}, i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0};
    endfunction

    function automatic logic [31:0] cb_imm(input logic [31:0] i);
        return {{24{i[12]}}, i[6:5], i[2], i[11:10], i[4:3], 1'b0};
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetched instructions with flush and occupancy count
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_BITS = 3
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                en,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  fq_entry_t           din,
    output fq_entry_t           dout,
    output logic [CNT_BITS-1:0] count,
    output logic                full,
    output logic                empty
);
    localparam int PW = $clog2(DEPTH);

    fq_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign full = count == CNT_BITS'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full && !flush;
    assign do_pop = pop && !empty && !flush;
    assign dout = mem[rd_ptr];

    // entry storage, written at the tail
    always_ff @(posedge clk_in) begin
        if (en && do_push) mem[wr_ptr] <= din;
    end

    // wrapping pointers and occupancy; flush empties the queue
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (en) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PW'(1);
                if (do_pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CNT_BITS'(do_push) - CNT_BITS'(do_pop);
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, 2-bit BHT prediction and queued issue to decoder (FETCH_BYPASS_EN: empty-queue bypass)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int BHT_BITS = 8,
    parameter int FETCH_DEPTH = 4,
    parameter int CNT_BITS = 3
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    output logic [31:0]         out_PC,
    output logic                ask_for,
    input  logic                give_you,
    input  logic [31:0]         g_ins,
    input  logic                rob_rs_slb_full,
    output logic                is_ins,
    output logic [31:0]         ins_addr,
    output logic [31:0]         ins,
    output logic                pred_jmp,
    output logic [31:0]         another_branch,
    input  logic                rob_clear,
    input  logic [31:0]         rob_new_pc,
    input  logic                cancel_stuck,
    input  logic [31:0]         jalr_new_pc,
    input  logic                is_res,
    input  logic [BHT_BITS-1:0] res_pc_part,
    input  logic                res_jmp,
    output logic [CNT_BITS-1:0] fq_count
);
    logic [31:0] pc_q, seq_pc, br_tgt, next_pc;
    logic stuck, halted;
    logic [1:0] bht [2**BHT_BITS];
    logic is_c, is_halt, is_jalr, is_jal, is_cj, is_br, taken;
    logic accept, bypass, push, pop, fq_full, fq_empty;
    fq_entry_t new_e, head, issue_e;

    assign out_PC = pc_q;
    assign ask_for = !stuck && !fq_full && !rob_clear;
    assign accept = rdy_in && ask_for && give_you;
`ifdef FETCH_BYPASS_EN
    assign bypass = accept && fq_empty && !rob_rs_slb_full;
`else
    assign bypass = 1'b0;
`endif
    assign push = accept && !bypass;
    assign pop = rdy_in && !rob_clear && !fq_empty && !rob_rs_slb_full;
    assign issue_e = pop ? head : new_e;

    // decode the incoming instruction and choose the next fetch PC
    always_comb begin
        is_c = g_ins[1:0] != 2'b11;
        seq_pc = pc_q + (is_c ? 32'd2 : 32'd4);
        is_halt = g_ins == HALT_INS;
        is_jalr = (!is_c && g_ins[6:0] == OJALR) ||
                  (g_ins[1:0] == OC_Q2 && g_ins[15:13] == CF3_JR && g_ins[6:2] == 5'd0);
        is_jal = !is_c && g_ins[6:0] == OJAL;
        is_cj = g_ins[1:0] == OC_Q1 && (g_ins[15:13] == CF3_J || g_ins[15:13] == CF3_JAL);
        is_br = (!is_c && g_ins[6:0] == OB) ||
                (g_ins[1:0] == OC_Q1 && (g_ins[15:13] == CF3_BEQZ || g_ins[15:13] == CF3_BNEZ));
        br_tgt = pc_q + (is_c ? cb_imm(g_ins) : b_imm(g_ins));
        taken = is_br && bht[pc_q[BHT_BITS:1]][1];
        next_pc = (is_halt || is_jalr) ? pc_q :
                  is_jal ? pc_q + j_imm(g_ins) :
                  is_cj ? pc_q + cj_imm(g_ins) :
                  taken ? br_tgt : seq_pc;
        new_e = '{pc: pc_q, ins: g_ins, pred: taken, alt: (is_br && !taken) ? br_tgt : seq_pc};
    end

    // PC and stall state; a HALT stall only yields to a ROB redirect
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_q <= '0;
            stuck <= 1'b0;
            halted <= 1'b0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                pc_q <= rob_new_pc;
                stuck <= 1'b0;
                halted <= 1'b0;
            end else if (accept) begin
                pc_q <= next_pc;
                stuck <= is_halt || is_jalr;
                halted <= is_halt;
            end else if (stuck && !halted && cancel_stuck) begin
                pc_q <= jalr_new_pc;
                stuck <= 1'b0;
            end
        end
    end

    // saturating 2-bit branch history counters
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < 2**BHT_BITS; k++) bht[k] <= 2'b01;
        end else if (rdy_in && is_res) begin
            bht[res_pc_part] <= res_jmp ? (bht[res_pc_part] == 2'b11 ? 2'b11 : bht[res_pc_part] + 2'b01)
                                        : (bht[res_pc_part] == 2'b00 ? 2'b00 : bht[res_pc_part] - 2'b01);
        end
    end

    // decoder-facing output registers, loaded from the queue head or the bypass path
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            is_ins <= 1'b0;
            ins_addr <= '0;
            ins <= '0;
            pred_jmp <= 1'b0;
            another_branch <= '0;
        end else if (rdy_in) begin
            is_ins <= !rob_clear && (pop || bypass);
            if (!rob_clear && (pop || bypass)) begin
                ins_addr <= issue_e.pc;
                ins <= issue_e.ins;
                pred_jmp <= issue_e.pred;
                another_branch <= issue_e.alt;
            end
        end
    end

    fetch_queue #(.DEPTH(FETCH_DEPTH), .CNT_BITS(CNT_BITS)) u_fq (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .en(rdy_in),
        .push(push),
        .pop(pop),
        .flush(rob_clear),
        .din(new_e),
        .dout(head),
        .count(fq_count),
        .full(fq_full),
        .empty(fq_empty)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard of expected decoder issues
module tb_fetch_unit;
    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] BEQ8 = 32'h00000463;
    localparam logic [31:0] CJM4 = 32'h0000bff5;
    localparam logic [31:0] JALR = 32'h00008067;
    localparam logic [31:0] HALT = 32'h0ff00513;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        pred;
        logic [31:0] alt;
    } exp_t;

    logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
    logic [31:0] out_PC, g_ins = '0, ins_addr, ins, another_branch, rob_new_pc = '0, jalr_new_pc = '0;
    logic ask_for, give_you = 1'b0, rob_rs_slb_full = 1'b0, is_ins, pred_jmp;
    logic rob_clear = 1'b0, cancel_stuck = 1'b0, is_res = 1'b0, res_jmp = 1'b0;
    logic [7:0] res_pc_part = '0;
    logic [2:0] fq_count;
    int checks = 0, errors = 0;
    exp_t sb[$];

    fetch_unit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .out_PC(out_PC), .ask_for(ask_for),
        .give_you(give_you), .g_ins(g_ins), .rob_rs_slb_full(rob_rs_slb_full), .is_ins(is_ins),
        .ins_addr(ins_addr), .ins(ins), .pred_jmp(pred_jmp), .another_branch(another_branch),
        .rob_clear(rob_clear), .rob_new_pc(rob_new_pc), .cancel_stuck(cancel_stuck),
        .jalr_new_pc(jalr_new_pc), .is_res(is_res), .res_pc_part(res_pc_part), .res_jmp(res_jmp),
        .fq_count(fq_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fetch(input logic [31:0] i);
        give_you = 1'b1;
        g_ins = i;
        tick();
        give_you = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] p);
        rob_clear = 1'b1;
        rob_new_pc = p;
        tick();
        rob_clear = 1'b0;
    endtask

    // scoreboard monitor: every issue must match the oldest expected entry
    always @(negedge clk_in) begin
        if (is_ins) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected actual=%h/%h required=none", ins_addr, ins);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({ins_addr, ins, pred_jmp, another_branch} !== e) begin
                    errors++;
                    $display("FAIL issue actual=%h/%h/%b/%h required=%h/%h/%b/%h",
                             ins_addr, ins, pred_jmp, another_branch, e.pc, e.ins, e.pred, e.alt);
                end
            end
        end
    end

    initial begin
        #1;
        chk("rst_is_ins", is_ins, 0);
        chk("rst_pc", out_PC, 0);
        chk("rst_count", fq_count, 0);
        idle(2);
        rst_in = 1'b0;
        chk("ask_after_rst", ask_for, 1);
        sb.push_back('{32'h0, ADDI, 1'b0, 32'h4});
        fetch(ADDI);
        chk("pc_after_addi", out_PC, 32'h4);
        chk("count_one", fq_count, 1);
        chk("latency_not_yet", is_ins, 0);
        tick();
        chk("latency_issue", is_ins, 1);
        idle(2);

        redirect(32'h10);
        sb.push_back('{32'h10, BEQ8, 1'b0, 32'h18});
        fetch(BEQ8);
        chk("beq_nt_pc", out_PC, 32'h14);
        is_res = 1'b1;
        res_jmp = 1'b1;
        res_pc_part = 8'd8;
        idle(2);
        is_res = 1'b0;
        idle(1);
        redirect(32'h10);
        sb.push_back('{32'h10, BEQ8, 1'b1, 32'h14});
        fetch(BEQ8);
        chk("beq_t_pc", out_PC, 32'h18);
        idle(2);
        redirect(32'h40);
        sb.push_back('{32'h40, CJM4, 1'b0, 32'h42});
        fetch(CJM4);
        chk("cj_pc", out_PC, 32'h3c);
        idle(3);

        rob_rs_slb_full = 1'b1;
        give_you = 1'b1;
        g_ins = ADDI;
        for (int i = 0; i < 4; i++) begin
            chk("fill_ask", ask_for, 1);
            sb.push_back('{32'h3c + 4 * i, ADDI, 1'b0, 32'h40 + 4 * i});
            tick();
        end
        chk("full_ask", ask_for, 0);
        chk("full_count", fq_count, 4);
        tick();
        chk("full_hold", fq_count, 4);
        give_you = 1'b0;
        rob_rs_slb_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_is_ins", is_ins, 1);
        end
        chk("drain_ask", ask_for, 1);
        chk("drain_count", fq_count, 0);
        chk("drain_pc", out_PC, 32'h4c);
        idle(1);

        redirect(32'h20);
        sb.push_back('{32'h20, JALR, 1'b0, 32'h24});
        fetch(JALR);
        chk("jalr_ask", ask_for, 0);
        idle(2);
        chk("jalr_stuck", ask_for, 0);
        cancel_stuck = 1'b1;
        jalr_new_pc = 32'h100;
        tick();
        cancel_stuck = 1'b0;
        chk("cancel_pc", out_PC, 32'h100);
        chk("cancel_ask", ask_for, 1);
        sb.push_back('{32'h100, HALT, 1'b0, 32'h104});
        fetch(HALT);
        chk("halt_ask", ask_for, 0);
        cancel_stuck = 1'b1;
        jalr_new_pc = 32'h300;
        tick();
        cancel_stuck = 1'b0;
        chk("halt_keep_ask", ask_for, 0);
        chk("halt_keep_pc", out_PC, 32'h100);
        idle(2);

        redirect(32'h180);
        rob_rs_slb_full = 1'b1;
        for (int i = 0; i < 3; i++) fetch(ADDI);
        chk("three_count", fq_count, 3);
        rob_clear = 1'b1;
        rob_new_pc = 32'h200;
        give_you = 1'b1;
        g_ins = ADDI;
        cancel_stuck = 1'b1;
        jalr_new_pc = 32'h300;
        #1;
        chk("clear_ask", ask_for, 0);
        tick();
        rob_clear = 1'b0;
        give_you = 1'b0;
        cancel_stuck = 1'b0;
        rob_rs_slb_full = 1'b0;
        chk("clear_count", fq_count, 0);
        chk("clear_is_ins", is_ins, 0);
        chk("clear_pc", out_PC, 32'h200);
        idle(3);

        sb.push_back('{32'h200, ADDI, 1'b0, 32'h204});
        fetch(ADDI);
        fetch(ADDI);
        @(negedge clk_in);
        #1;
        chk("pre_rst_is_ins", is_ins, 1);
        rst_in = 1'b1;
        #1;
        chk("arst_is_ins", is_ins, 0);
        chk("arst_pc", out_PC, 0);
        chk("arst_count", fq_count, 0);
        tick();
        rst_in = 1'b0;
        idle(3);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
